pipe_ctrl: RTL

Hazard and sequencing controller for the 5-stage RISC-V pipeline; drives the stall/flush inputs of the IF/ID, ID/EX, EX/ME and ME/WB registers and the PC select.
- Detects load-use hazards, generates forwarding selects for EX, and resolves ME-stage redirects (branch/jal/jalr).
- Sequences data-memory accesses through a req/ready handshake with a wait-state FSM and a watchdog.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/fwd_unit.sv | 30 +++
 rtl/pipe_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller and its forwarding units.
package pipe_pkg;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   localparam logic [1:0] PCSEL_SEQ = 2'b00;
   localparam logic [1:0] PCSEL_IMM = 2'b01;
   localparam logic [1:0] PCSEL_RS1 = 2'b10;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_ME = 2'b01;
   localparam logic [1:0] FWD_WB = 2'b10;

   localparam logic [1:0] NPC_PC_IMM  = 2'b00;
   localparam logic [1:0] NPC_NEXT_PC = 2'b01;
   localparam logic [1:0] NPC_RS1_IMM = 2'b10;
   localparam logic [1:0] NPC_RSVD    = 2'b11;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register; ME result wins over WB.
module fwd_unit
   import pipe_pkg::*;
(
   input  logic [4:0] i_src,
   input  logic [4:0] i_me_rd,
   input  logic       i_me_write,
   input  logic       i_me_load,
   input  logic [4:0] i_wb_rd,
   input  logic       i_wb_write,
   output logic [1:0] o_fwd
);

   logic w_me_hit;
   logic w_wb_hit;

   // A load in ME has no data yet, so it can never be a forwarding source.
   assign w_me_hit = i_me_write && !i_me_load && (i_me_rd != 5'd0) && (i_me_rd == i_src);
   assign w_wb_hit = i_wb_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_src);

   always_comb begin
      o_fwd = FWD_RF;
      if (w_me_hit) begin
         o_fwd = FWD_ME;
      end else if (w_wb_hit) begin
         o_fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller: load-use stalls, ME redirects, forwarding selects
// and a data-memory wait-state FSM with a sticky watchdog.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_useRs1,
   input  logic        id_useRs2,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_writeReg,
   input  logic        ex_aluOut_WB_memOut,
   input  logic [4:0]  me_rd,
   input  logic        me_writeReg,
   input  logic        me_aluOut_WB_memOut,
   input  logic        me_mem_w,
   input  logic [1:0]  me_pcImm_NEXTPC_rs1Imm,
   input  logic        me_conditionBranch,
   input  logic        me_brTaken,
   input  logic [4:0]  wb_rd,
   input  logic        wb_writeReg,
   input  logic        dmem_ready,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        id_ex_stall,
   output logic        ex_me_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_me_flush,
   output logic        me_wb_flush,
   output logic [1:0]  pc_sel,
   output logic [1:0]  fwdA,
   output logic [1:0]  fwdB,
   output logic        dmem_req,
   output logic        mem_err,
   output logic [31:0] stall_cnt
);

   localparam logic [31:0] TIMEOUT = 32'(MEM_TIMEOUT);

   state_e      r_state;
   state_e      w_state_d;
   logic [31:0] r_wdog;
   logic [31:0] w_wdog_inc;
   logic        r_mem_err;
   logic [31:0] r_stall_cnt;

   logic        w_mem_op;
   logic        w_redirect;
   logic        w_load_use;
   logic [1:0]  w_fwd_a;
   logic [1:0]  w_fwd_b;

   assign w_mem_op   = me_aluOut_WB_memOut | me_mem_w;
   assign w_redirect = (me_pcImm_NEXTPC_rs1Imm == NPC_RS1_IMM) ||
                       ((me_pcImm_NEXTPC_rs1Imm == NPC_PC_IMM) &&
                        (!me_conditionBranch || me_brTaken));
   assign w_load_use = ex_writeReg && ex_aluOut_WB_memOut && (ex_rd != 5'd0) &&
                       ((id_useRs1 && (id_rs1 == ex_rd)) || (id_useRs2 && (id_rs2 == ex_rd)));

   always_comb begin
      w_state_d   = r_state;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      id_ex_stall = 1'b0;
      ex_me_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_me_flush = 1'b0;
      me_wb_flush = 1'b0;
      pc_sel      = PCSEL_SEQ;
      dmem_req    = 1'b0;
      // Outputs are held quiet for the whole reset, even mid-access.
      if (rst_n) begin
         unique case (r_state)
            ST_RUN: begin
               dmem_req = w_mem_op;
               if (w_mem_op && !dmem_ready) begin
                  w_state_d   = ST_MEM_WAIT;
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_stall = 1'b1;
                  ex_me_stall = 1'b1;
                  me_wb_flush = 1'b1;
               end else if (w_redirect) begin
                  pc_sel      = (me_pcImm_NEXTPC_rs1Imm == NPC_RS1_IMM) ? PCSEL_RS1 : PCSEL_IMM;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  ex_me_flush = 1'b1;
               end else if (w_load_use) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               dmem_req = 1'b1;
               if (!dmem_ready) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_stall = 1'b1;
                  ex_me_stall = 1'b1;
                  me_wb_flush = 1'b1;
               end else begin
                  w_state_d = ST_RUN;
                  if (w_load_use) begin
                     pc_stall    = 1'b1;
                     if_id_stall = 1'b1;
                     id_ex_flush = 1'b1;
                  end
               end
            end
            default: w_state_d = ST_RUN;
         endcase
      end
   end

   fwd_unit u_fwd_a (
      .i_src      (ex_rs1),
      .i_me_rd    (me_rd),
      .i_me_write (me_writeReg),
      .i_me_load  (me_aluOut_WB_memOut),
      .i_wb_rd    (wb_rd),
      .i_wb_write (wb_writeReg),
      .o_fwd      (w_fwd_a)
   );

   fwd_unit u_fwd_b (
      .i_src      (ex_rs2),
      .i_me_rd    (me_rd),
      .i_me_write (me_writeReg),
      .i_me_load  (me_aluOut_WB_memOut),
      .i_wb_rd    (wb_rd),
      .i_wb_write (wb_writeReg),
      .o_fwd      (w_fwd_b)
   );

   assign fwdA = rst_n ? w_fwd_a : FWD_RF;
   assign fwdB = rst_n ? w_fwd_b : FWD_RF;

   assign w_wdog_inc = r_wdog + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_wdog      <= 32'd0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= 32'd0;
      end else begin
         r_state <= w_state_d;
         if (r_state == ST_RUN) begin
            r_wdog <= 32'd0;
         end else if (r_wdog < TIMEOUT) begin
            // Saturate so a stuck access cannot wrap the counter.
            r_wdog <= w_wdog_inc;
         end
         if ((r_state == ST_MEM_WAIT) && (w_wdog_inc >= TIMEOUT)) begin
            r_mem_err <= 1'b1;
         end
         if (pc_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign mem_err   = r_mem_err;
   assign stall_cnt = r_stall_cnt;

endmodule
